// File: rtl/clock_health_monitor.sv
// clock_health_monitor: per-clock frequency window check with hysteresis, lock-loss
// tracking and sticky alarms. Define CLK_MON_IRQ_EN to build the registered irq output.

module clock_health_chan #(
  parameter int GOOD_COUNT = 4,
  parameter int BAD_COUNT  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic lock_s,
  input  logic upd,
  input  logic in_win,
  input  logic clear,
  output logic good,
  output logic alarm
);
  typedef enum logic [1:0] {S_INIT, S_GOOD, S_BAD} state_t;

  localparam logic [3:0] GOOD_N = 4'(GOOD_COUNT);
  localparam logic [3:0] BAD_N  = 4'(BAD_COUNT);

  state_t     state;
  logic [3:0] good_cnt, bad_cnt;
  logic       to_bad, to_good;

  assign to_bad  = en & lock_s & upd & ~in_win & (state == S_GOOD) & (bad_cnt + 4'd1 == BAD_N);
  assign to_good = (good_cnt + 4'd1 == GOOD_N);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_INIT;
      good_cnt <= '0;
      bad_cnt  <= '0;
      good     <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      // a GOOD->BAD transition in the clear cycle keeps the sticky set
      if (to_bad)     alarm <= 1'b1;
      else if (clear) alarm <= 1'b0;

      if (!en) begin
        state    <= S_GOOD;
        good     <= 1'b1;
        good_cnt <= '0;
        bad_cnt  <= '0;
      end else if (!lock_s) begin
        state    <= S_INIT;
        good     <= 1'b0;
        good_cnt <= '0;
        bad_cnt  <= '0;
      end else if (upd) begin
        case (state)
          S_INIT, S_BAD: begin
            if (!in_win) good_cnt <= '0;
            else if (to_good) begin
              state    <= S_GOOD;
              good     <= 1'b1;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end else good_cnt <= good_cnt + 4'd1;
          end
          S_GOOD: begin
            if (in_win) bad_cnt <= '0;
            else if (to_bad) begin
              state    <= S_BAD;
              good     <= 1'b0;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end else bad_cnt <= bad_cnt + 4'd1;
          end
          default: begin
            state <= S_INIT;
            good  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

module clock_health_monitor #(
  parameter int NUM_CLK    = 3,
  parameter int TOL_HZ     = 12500,
  parameter int GOOD_COUNT = 4,
  parameter int BAD_COUNT  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    meas_tick,
  input  logic [NUM_CLK-1:0][31:0] fc_in,
  input  logic [NUM_CLK-1:0][31:0] exp_freq,
  input  logic                    lock_in,
  input  logic                    clear,
  output logic [NUM_CLK-1:0]      clk_good,
  output logic [NUM_CLK-1:0]      alarm_sticky,
  output logic                    lock_lost_sticky,
  output logic [15:0]             lock_loss_count,
  output logic                    all_good,
  output logic                    irq
);
  localparam int STAGES = 1;

  logic               lock_m, lock_s, lock_d, lock_fall;
  logic [STAGES:0]    vld_pipe;
  logic [NUM_CLK-1:0] in_win_c, in_win_q, ch_en;

  assign vld_pipe[0] = meas_tick & lock_s;
  assign lock_fall   = lock_d & ~lock_s;

  for (genvar g = 0; g < NUM_CLK; g++) begin : g_ch
    logic [32:0] fc33, ex33, diff;
    assign fc33        = {1'b0, fc_in[g]};
    assign ex33        = {1'b0, exp_freq[g]};
    assign diff        = (fc33 >= ex33) ? fc33 - ex33 : ex33 - fc33;
    assign in_win_c[g] = (diff <= 33'(TOL_HZ));
    assign ch_en[g]    = (exp_freq[g] != 32'd0);

    clock_health_chan #(.GOOD_COUNT(GOOD_COUNT), .BAD_COUNT(BAD_COUNT)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (ch_en[g]),
      .lock_s (lock_s),
      .upd    (vld_pipe[STAGES]),
      .in_win (in_win_q[g]),
      .clear  (clear),
      .good   (clk_good[g]),
      .alarm  (alarm_sticky[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_m           <= 1'b0;
      lock_s           <= 1'b0;
      lock_d           <= 1'b0;
      vld_pipe[STAGES:1] <= '0;
      in_win_q         <= '0;
      lock_lost_sticky <= 1'b0;
      lock_loss_count  <= '0;
      all_good         <= 1'b0;
    end else begin
      lock_m <= lock_in;
      lock_s <= lock_m;
      lock_d <= lock_s;
      // losing lock drops any compare result still in flight
      vld_pipe[STAGES:1] <= lock_s ? vld_pipe[STAGES-1:0] : '0;
      if (vld_pipe[0]) in_win_q <= in_win_c;

      if (lock_fall) begin
        lock_lost_sticky <= 1'b1;
        if (clear)                         lock_loss_count <= 16'd1;
        else if (lock_loss_count != 16'hFFFF) lock_loss_count <= lock_loss_count + 16'd1;
      end else if (clear) begin
        lock_lost_sticky <= 1'b0;
        lock_loss_count  <= '0;
      end

      all_good <= (&clk_good) & lock_s;
    end
  end

`ifdef CLK_MON_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= (|alarm_sticky) | lock_lost_sticky;
  end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_clock_health_monitor.sv
// Directed bench for clock_health_monitor: hysteresis, tolerance edges, lock loss, clear, reset.
module tb_clock_health_monitor;
  localparam int N = 3;
  localparam logic [31:0] F0 = 32'd125000000;
  localparam logic [31:0] F1 = 32'd250000000;

  logic             clk = 1'b0;
  logic             rst, meas_tick, lock_in, clear;
  logic [N-1:0][31:0] fc_in, exp_freq;
  logic [N-1:0]     clk_good, alarm_sticky;
  logic             lock_lost_sticky, all_good, irq;
  logic [15:0]      lock_loss_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clock_health_monitor #(.NUM_CLK(N), .TOL_HZ(12500), .GOOD_COUNT(4), .BAD_COUNT(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .meas_tick        (meas_tick),
    .fc_in            (fc_in),
    .exp_freq         (exp_freq),
    .lock_in          (lock_in),
    .clear            (clear),
    .clk_good         (clk_good),
    .alarm_sticky     (alarm_sticky),
    .lock_lost_sticky (lock_lost_sticky),
    .lock_loss_count  (lock_loss_count),
    .all_good         (all_good),
    .irq              (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one measurement strobe; consecutive calls give back-to-back ticks
  task automatic tick(input logic [31:0] f0);
    fc_in[0]  = f0;
    meas_tick = 1'b1;
    @(posedge clk);
    #1;
    meas_tick = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b0; meas_tick = 1'b0; lock_in = 1'b0; clear = 1'b0;
    exp_freq[0] = F0; exp_freq[1] = F1; exp_freq[2] = 32'd0;
    fc_in[0] = F0; fc_in[1] = 32'd250010000; fc_in[2] = 32'd0;
    #1;
    chk("rst_good", clk_good, 0);
    chk("rst_alarm", alarm_sticky, 0);
    chk("rst_lsticky", lock_lost_sticky, 0);
    chk("rst_lcount", lock_loss_count, 0);
    chk("rst_allgood", all_good, 0);
    chk("rst_irq", irq, 0);

    cyc(2);
    rst = 1'b1; lock_in = 1'b1;
    cyc(5);
    chk("disabled_ch_good", clk_good, 3'b100);

    // acquisition: 4 in-window ticks, ch1 off by 10 kHz
    tick(F0); tick(F0); tick(F0); tick(F0);
    chk("acq_before_lat", clk_good, 3'b100);
    cyc(1);
    chk("acq_good", clk_good, 3'b111);
    chk("acq_allgood_lag", all_good, 0);
    cyc(1);
    chk("acq_allgood", all_good, 1);

    // tolerance edge: 12501 out, 12500 in
    tick(32'd125012501); tick(32'd125012500);
    cyc(1);
    chk("single_bad_holds", clk_good, 3'b111);
    chk("single_bad_noalarm", alarm_sticky, 0);
    tick(32'd125012501); tick(32'd125012501);
    chk("one_of_two_bad", clk_good, 3'b111);
    cyc(1);
    chk("two_bad_good", clk_good, 3'b110);
    chk("two_bad_alarm", alarm_sticky, 3'b001);
    cyc(1);
    chk("two_bad_allgood", all_good, 0);
`ifdef CLK_MON_IRQ_EN
    chk("irq_alarm", irq, 1);
`else
    chk("irq_tied", irq, 0);
`endif

    // recovery: 3 in, 1 out, 3 in back-to-back, then the 4th in
    for (int i = 0; i < 7; i++) tick((i == 3) ? 32'd124987499 : F0);
    cyc(1);
    chk("recover_pending", clk_good, 3'b110);
    tick(F0);
    cyc(1);
    chk("recover_good", clk_good, 3'b111);
    chk("recover_alarm_kept", alarm_sticky, 3'b001);

    pulse_clear();
    chk("clear_alarm", alarm_sticky, 0);
    cyc(1);
    chk("clear_irq", irq, 0);

    // three lock drops
    for (int i = 0; i < 3; i++) begin
      lock_in = 1'b0;
      cyc(6);
      if (i == 0) begin
        chk("lock_low_init", clk_good, 3'b100);
        chk("lock_low_allgood", all_good, 0);
      end
      lock_in = 1'b1;
      cyc(6);
    end
    chk("lock_count3", lock_loss_count, 3);
    chk("lock_sticky", lock_lost_sticky, 1);
    chk("lock_no_alarm", alarm_sticky, 0);
    chk("lock_chan_init", clk_good, 3'b100);

    // clear in the same cycle as the detected lock fall
    lock_in = 1'b0;
    cyc(2);
    pulse_clear();
    chk("clr_fall_sticky", lock_lost_sticky, 1);
    chk("clr_fall_count", lock_loss_count, 1);
`ifdef CLK_MON_IRQ_EN
    chk("irq_lock", irq, 1);
`endif
    cyc(2);
    pulse_clear();
    chk("clr_sticky", lock_lost_sticky, 0);
    chk("clr_count", lock_loss_count, 0);
    cyc(1);
    chk("clr_irq", irq, 0);

    // saturation from a preloaded count
    lock_in = 1'b1;
    cyc(6);
    force dut.lock_loss_count = 16'hFFFE;
    cyc(1);
    release dut.lock_loss_count;
    cyc(1);
    for (int i = 0; i < 2; i++) begin
      lock_in = 1'b0;
      cyc(6);
      chk("sat_count", lock_loss_count, 16'hFFFF);
      lock_in = 1'b1;
      cyc(6);
    end

    // async reset with good_cnt=2
    tick(F0); tick(F0);
    cyc(1);
    #2 rst = 1'b0;
    #1;
    chk("arst_good", clk_good, 0);
    chk("arst_count", lock_loss_count, 0);
    chk("arst_sticky", lock_lost_sticky, 0);
    chk("arst_allgood", all_good, 0);
    cyc(1);
    rst = 1'b1;
    cyc(5);
    tick(F0); tick(F0); tick(F0);
    cyc(1);
    chk("arst_fresh3", clk_good, 3'b100);
    tick(F0);
    cyc(1);
    chk("arst_fresh4", clk_good, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
